// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin MUX_4 arbiter.
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the requesters, the shared consumer and the arbiter.
interface mux4_rr_arbiter_if;
    import mux4_rr_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               ready;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               out_valid;
    logic               fire;
    logic               busy;

    // master is the arbiter side; slave is the producer/consumer side.
    modport master (
        input  req,
        input  ready,
        output gnt,
        output sel,
        output out_valid,
        output fire,
        output busy
    );

    modport slave (
        output req,
        output ready,
        input  gnt,
        input  sel,
        input  out_valid,
        input  fire,
        input  busy
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating-priority search: first set candidate bit at ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] cand_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [SEL_W-1:0]   idx_o
);

    logic [SEL_W-1:0] probe;

    // Walk from lowest priority to highest so the last hit is the winner.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        probe   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            probe = ptr_i + SEL_W'(k);
            if (cand_i[probe]) begin
                found_o = 1'b1;
                idx_o   = probe;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the registered Sel/grant of a shared MUX_4 datapath,
// with a burst cap that only bites when another requester is waiting.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; gnt=0, sel=0, busy=0; any request is granted next edge
//   GRANT | owner sel_q holds the mux; released on req drop or burst cap
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    mux4_rr_arbiter_if.master   bus
);

    if (MAX_BURST < 1 || MAX_BURST > 255 || MAX_BURST > ((1 << CNT_W) - 1)) begin : g_bad_param
        $error("mux4_rr_arbiter: MAX_BURST out of range or does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0] pick_cand;
    logic [SEL_W-1:0]   pick_ptr;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;

    logic               out_valid;
    logic               fire;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cap_hit;
    logic               others_wait;
    logic               release_a;
    logic               release_b;
    logic [SEL_W-1:0]   after_owner;

    assign out_valid   = |(gnt_q & bus.req);
    assign fire        = out_valid & bus.ready;
    assign cnt_inc     = beat_cnt_q + CNT_W'(1);
    assign cap_hit     = fire && (cnt_inc == MAX_CNT);
    assign others_wait = |(bus.req & ~gnt_q);
    assign release_a   = ~bus.req[sel_q];
    assign release_b   = cap_hit & others_wait;
    assign after_owner = sel_q + SEL_W'(1);

    // One search engine serves both the idle pick and the hand-over pick.
    rr_pick4 u_pick (
        .cand_i  (pick_cand),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        pick_cand  = bus.req;
        pick_ptr   = ptr_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    gnt_d      = idx_to_onehot(pick_idx);
                    sel_d      = pick_idx;
                    busy_d     = 1'b1;
                    beat_cnt_d = '0;
                end
            end

            GRANT: begin
                // The owner is masked out so a release never re-grants it directly.
                pick_cand = bus.req & ~gnt_q;
                pick_ptr  = after_owner;
                if (release_a || release_b) begin
                    ptr_d      = after_owner;
                    beat_cnt_d = '0;
                    if (pick_found) begin
                        gnt_d = idx_to_onehot(pick_idx);
                        sel_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        sel_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else if (fire) begin
                    beat_cnt_d = cap_hit ? '0 : cnt_inc;
                end
            end

            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                sel_d      = '0;
                busy_d     = 1'b0;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid;
    assign bus.fire      = fire;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with MAX_BURST=4.
module tb_mux4_rr_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(
        .MAX_BURST (4),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.req   = 4'b0000;
        bus.ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.req   = 4'b1111;
        bus.ready = 1'b1;
        cyc();
        cyc();
        #1;
        checks++;
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=%b", bus.gnt, 4'b0000); end
        checks++;
        if (bus.sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.fire !== 1'b0) begin failures++; $display("FAIL reset_fire got=%b exp=0", bus.fire); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.req   = 4'b0100;
        bus.ready = 1'b1;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_latency got=%b exp=%b", bus.gnt, 4'b0000); end
        cyc();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2 || bus.fire !== 1'b1 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL single_beat beat=%0d gnt=%b sel=%0d fire=%b busy=%b exp gnt=0100 sel=2 fire=1 busy=1",
                         i, bus.gnt, bus.sel, bus.fire, bus.busy);
            end
            cyc();
        end
        bus.req = 4'b0000;
        cyc();
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_release gnt=%b busy=%b exp gnt=0000 busy=0", bus.gnt, bus.busy);
        end
    endtask

    task automatic test_burst_rotation();
        logic [1:0] exp_sel [17];
        exp_sel = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                    2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        do_reset();
        bus.req   = 4'b1111;
        bus.ready = 1'b1;
        cyc();
        for (int i = 0; i < 17; i++) begin
            #1;
            checks++;
            if (bus.sel !== exp_sel[i] || bus.gnt !== (4'b0001 << exp_sel[i]) || bus.fire !== 1'b1) begin
                failures++;
                $display("FAIL rotation cycle=%0d sel=%0d gnt=%b fire=%b exp sel=%0d gnt=%b fire=1",
                         i, bus.sel, bus.gnt, bus.fire, exp_sel[i], 4'b0001 << exp_sel[i]);
            end
            cyc();
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        bus.req   = 4'b1010;
        bus.ready = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.gnt !== 4'b0010 || bus.fire !== 1'b1) begin
                failures++;
                $display("FAIL drop_owner1 beat=%0d gnt=%b fire=%b exp gnt=0010 fire=1", i, bus.gnt, bus.fire);
            end
            cyc();
        end
        bus.req = 4'b1000;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.fire !== 1'b0) begin
            failures++;
            $display("FAIL drop_valid out_valid=%b fire=%b exp 0 0", bus.out_valid, bus.fire);
        end
        cyc();
        #1;
        checks++;
        if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL drop_handover gnt=%b sel=%0d busy=%b exp gnt=1000 sel=3 busy=1", bus.gnt, bus.sel, bus.busy);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req   = 4'b0011;
        bus.ready = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.gnt !== 4'b0001 || bus.fire !== 1'b0 || bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_stall cycle=%0d gnt=%b fire=%b valid=%b exp gnt=0001 fire=0 valid=1",
                         i, bus.gnt, bus.fire, bus.out_valid);
            end
            cyc();
        end
        bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.gnt !== 4'b0001 || bus.fire !== 1'b1) begin
                failures++;
                $display("FAIL bp_beat beat=%0d gnt=%b fire=%b exp gnt=0001 fire=1", i, bus.gnt, bus.fire);
            end
            cyc();
        end
        #1;
        checks++;
        if (bus.gnt !== 4'b0010 || bus.sel !== 2'd1) begin
            failures++;
            $display("FAIL bp_cap gnt=%b sel=%0d exp gnt=0010 sel=1", bus.gnt, bus.sel);
        end
    endtask

    task automatic test_last_release();
        do_reset();
        bus.req   = 4'b1000;
        bus.ready = 1'b1;
        cyc();
        #1;
        checks++;
        if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3) begin
            failures++;
            $display("FAIL last_grant gnt=%b sel=%0d exp gnt=1000 sel=3", bus.gnt, bus.sel);
        end
        cyc();
        bus.req = 4'b0000;
        cyc();
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.sel !== 2'd0) begin
            failures++;
            $display("FAIL last_idle gnt=%b busy=%b sel=%0d exp gnt=0000 busy=0 sel=0", bus.gnt, bus.busy, bus.sel);
        end
        cyc();
        bus.req = 4'b1001;
        cyc();
        #1;
        checks++;
        if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin
            failures++;
            $display("FAIL last_wrap gnt=%b sel=%0d exp gnt=0001 sel=0", bus.gnt, bus.sel);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.req   = 4'b0100;
        bus.ready = 1'b1;
        cyc();
        bus.req = 4'b0000;
        cyc();
        bus.req = 4'b0100;
        cyc();
        cyc();
        cyc();
        #1;
        checks++;
        if (bus.gnt !== 4'b0100 || bus.fire !== 1'b1) begin
            failures++;
            $display("FAIL midrst_owner gnt=%b fire=%b exp gnt=0100 fire=1", bus.gnt, bus.fire);
        end
        reset = 1'b1;
        cyc();
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.sel !== 2'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear gnt=%b sel=%0d busy=%b exp gnt=0000 sel=0 busy=0", bus.gnt, bus.sel, bus.busy);
        end
        reset   = 1'b0;
        bus.req = 4'b1111;
        cyc();
        #1;
        checks++;
        if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin
            failures++;
            $display("FAIL midrst_ptr gnt=%b sel=%0d exp gnt=0001 sel=0", bus.gnt, bus.sel);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.req   = 4'b0000;
        bus.ready = 1'b0;
        test_reset();
        test_single();
        test_burst_rotation();
        test_owner_drop();
        test_backpressure();
        test_last_release();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
